// File: rtl/riscv_dmem_responder.sv
// Data-memory responder for the LSU memory port: byte-strobed word RAM with a fixed-latency,
// in-order tagged response pipeline and a flush busy window that holds off new requests.
module riscv_dmem_responder #(
  parameter int DEPTH_WORDS  = 1024,
  parameter int ACK_LATENCY  = 1,
  parameter int FLUSH_CYCLES = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_wr_i,
  input  logic        mem_rd_i,
  input  logic [3:0]  mem_wr_i,
  input  logic        mem_cacheable_i,
  input  logic [10:0] mem_req_tag_i,
  input  logic        mem_invalidate_i,
  input  logic        mem_writeback_i,
  input  logic        mem_flush_i,
  output logic [31:0] mem_data_rd_o,
  output logic        mem_accept_o,
  output logic        mem_ack_o,
  output logic        mem_error_o,
  output logic [10:0] mem_resp_tag_o,
  output logic        mem_load_fault_o,
  output logic        mem_store_fault_o
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam int PW = 47;

  typedef enum logic [0:0] {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  logic          load_s, store_s, cop_s, request_s, accept_s, legal_s, in_range_s;
  logic [29:0]   word_idx_s;
  logic [AW-1:0] ram_idx_s;
  logic [31:0]   rdata_s;
  logic          err_s, lf_s, sf_s;
  logic [PW-1:0] entry_s;
  logic          unused_s;

  logic [31:0]   ram_r  [DEPTH_WORDS];
  logic [PW-1:0] pipe_r [ACK_LATENCY];
  state_t        state_r;
  logic [CW-1:0] count_r;
  logic          accept_r;

  assign unused_s = ^{mem_cacheable_i, mem_addr_i[1:0]};

  // Request decode and construction of the response entry for this cycle's accept.
  always_comb begin
    load_s     = mem_rd_i;
    store_s    = |mem_wr_i;
    cop_s      = mem_invalidate_i | mem_writeback_i | mem_flush_i;
    request_s  = load_s | store_s | cop_s;
    accept_s   = request_s & accept_r;
    legal_s    = ({1'b0, load_s} + {1'b0, store_s} + {1'b0, cop_s}) <= 2'd1;
    word_idx_s = mem_addr_i[31:2];
    in_range_s = word_idx_s < 30'(DEPTH_WORDS);
    ram_idx_s  = word_idx_s[AW-1:0];
    rdata_s    = 32'h0;
    err_s      = 1'b0;
    lf_s       = 1'b0;
    sf_s       = 1'b0;
    if (!legal_s) begin
      err_s = 1'b1;
    end else if (load_s) begin
      if (in_range_s) begin
        rdata_s = ram_r[ram_idx_s];
      end else begin
        err_s = 1'b1;
        lf_s  = 1'b1;
      end
    end else if (store_s && !in_range_s) begin
      err_s = 1'b1;
      sf_s  = 1'b1;
    end else begin
      rdata_s = 32'h0;
    end
    if (accept_s) begin
      entry_s = {1'b1, mem_req_tag_i, rdata_s, err_s, lf_s, sf_s};
    end else begin
      entry_s = '0;
    end
  end

  // Word RAM with per-byte writes; deliberately not cleared by reset.
  always_ff @(posedge clk_i) begin
    if (accept_s && legal_s && store_s && in_range_s) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wr_i[b]) begin
          ram_r[ram_idx_s][8*b +: 8] <= mem_data_wr_i[8*b +: 8];
        end
      end
    end
  end

  // Response shift pipeline; an empty slot is all zeros so outputs idle at 0.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ACK_LATENCY; i++) begin
        pipe_r[i] <= '0;
      end
    end else begin
      pipe_r[0] <= entry_s;
      for (int i = 1; i < ACK_LATENCY; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  // Accept FSM: a legal flush closes the request window for FLUSH_CYCLES cycles.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r  <= IDLE;
      count_r  <= '0;
      accept_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && legal_s && mem_flush_i) begin
            state_r  <= FLUSH;
            count_r  <= CW'(FLUSH_CYCLES);
            accept_r <= 1'b0;
          end else begin
            accept_r <= 1'b1;
          end
        end
        FLUSH: begin
          if (count_r == CW'(1)) begin
            state_r  <= IDLE;
            accept_r <= 1'b1;
          end else begin
            count_r  <= count_r - CW'(1);
            accept_r <= 1'b0;
          end
        end
        default: begin
          state_r  <= IDLE;
          accept_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem_accept_o = accept_r;
  assign {mem_ack_o, mem_resp_tag_o, mem_data_rd_o,
          mem_error_o, mem_load_fault_o, mem_store_fault_o} = pipe_r[ACK_LATENCY-1];

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Bench for riscv_dmem_responder: two instances (ACK latency 1 and 3) share one stimulus stream
// and are checked against a word-array memory model and per-request expected responses.
module tb_riscv_dmem_responder;

  localparam int DEPTH = 1024;

  typedef struct packed {
    logic        ack;
    logic [10:0] tag;
    logic [31:0] data;
    logic        err;
    logic        lf;
    logic        sf;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] addr, wdata;
  logic        rd, cacheable, inv, wb, fl;
  logic [3:0]  wr;
  logic [10:0] tag;

  logic [31:0] a_data, b_data;
  logic        a_accept, a_ack, a_err, a_lf, a_sf;
  logic        b_accept, b_ack, b_err, b_lf, b_sf;
  logic [10:0] a_tag, b_tag;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  riscv_dmem_responder #(.DEPTH_WORDS(DEPTH), .ACK_LATENCY(1), .FLUSH_CYCLES(8)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .mem_addr_i(addr), .mem_data_wr_i(wdata), .mem_rd_i(rd),
    .mem_wr_i(wr), .mem_cacheable_i(cacheable), .mem_req_tag_i(tag), .mem_invalidate_i(inv),
    .mem_writeback_i(wb), .mem_flush_i(fl), .mem_data_rd_o(a_data), .mem_accept_o(a_accept),
    .mem_ack_o(a_ack), .mem_error_o(a_err), .mem_resp_tag_o(a_tag),
    .mem_load_fault_o(a_lf), .mem_store_fault_o(a_sf));

  riscv_dmem_responder #(.DEPTH_WORDS(DEPTH), .ACK_LATENCY(3), .FLUSH_CYCLES(8)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .mem_addr_i(addr), .mem_data_wr_i(wdata), .mem_rd_i(rd),
    .mem_wr_i(wr), .mem_cacheable_i(cacheable), .mem_req_tag_i(tag), .mem_invalidate_i(inv),
    .mem_writeback_i(wb), .mem_flush_i(fl), .mem_data_rd_o(b_data), .mem_accept_o(b_accept),
    .mem_ack_o(b_ack), .mem_error_o(b_err), .mem_resp_tag_o(b_tag),
    .mem_load_fault_o(b_lf), .mem_store_fault_o(b_sf));

  function automatic resp_t obs_a();
    return {a_ack, a_tag, a_data, a_err, a_lf, a_sf};
  endfunction

  function automatic resp_t obs_b();
    return {b_ack, b_tag, b_data, b_err, b_lf, b_sf};
  endfunction

  task automatic idle_in();
    rd = 1'b0; wr = 4'h0; inv = 1'b0; wb = 1'b0; fl = 1'b0;
    addr = 32'h0; wdata = 32'h0; tag = 11'h0; cacheable = 1'b0;
  endtask

  // Expected response from the request rules; updates the memory model for legal stores.
  task automatic model_req(input logic r, input logic [3:0] w, input logic [31:0] ad,
                           input logic [31:0] wd, input logic [10:0] t, input logic i,
                           input logic b, input logic f, output resp_t e);
    int kinds;
    int unsigned widx;
    kinds = int'(r) + int'(w != 4'h0) + int'(i | b | f);
    widx  = ad >> 2;
    e = '0;
    e.ack = 1'b1;
    e.tag = t;
    if (kinds > 1) begin
      e.err = 1'b1;
    end else if (r) begin
      if (widx >= DEPTH) begin e.err = 1'b1; e.lf = 1'b1; end
      else e.data = model_mem[widx];
    end else if (w != 4'h0) begin
      if (widx >= DEPTH) begin e.err = 1'b1; e.sf = 1'b1; end
      else for (int k = 0; k < 4; k++) if (w[k]) model_mem[widx][8*k +: 8] = wd[8*k +: 8];
    end
  endtask

  task automatic issue(input logic r, input logic [3:0] w, input logic [31:0] ad,
                       input logic [31:0] wd, input logic [10:0] t, input logic i,
                       input logic b, input logic f, output resp_t e);
    model_req(r, w, ad, wd, t, i, b, f, e);
    rd = r; wr = w; addr = ad; wdata = wd; tag = t; inv = i; wb = b; fl = f;
    cacheable = 1'($urandom);
  endtask

  // Single request: wait for accept, return the latency-1 and latency-3 responses.
  task automatic do_req(input logic r, input logic [3:0] w, input logic [31:0] ad,
                        input logic [31:0] wd, input logic [10:0] t, input logic i,
                        input logic b, input logic f, output resp_t e, output resp_t ra,
                        output resp_t rb);
    int waited = 0;
    issue(r, w, ad, wd, t, i, b, f, e);
    while (a_accept !== 1'b1 && waited < 30) begin
      @(posedge clk); #1; waited++;
    end
    if (waited >= 30) begin
      checks++; errors++;
      $display("FAIL accept_timeout got accept=%b required 1", a_accept);
    end
    @(posedge clk); #1;
    idle_in();
    ra = obs_a();
    repeat (2) @(posedge clk);
    #1;
    rb = obs_b();
  endtask

  task automatic test_reset();
    idle_in();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a_accept, obs_a(), b_accept, obs_b()} !== '0) begin
      errors++; $display("FAIL reset_outputs got %h/%h required 0", obs_a(), obs_b());
    end
    #2 rst_n = 1'b1;
    #1 checks++;
    if (a_accept !== 1'b0) begin errors++; $display("FAIL accept_before_edge got %b required 0", a_accept); end
    @(posedge clk); #1;
    checks++;
    if (a_accept !== 1'b1 || b_accept !== 1'b1) begin
      errors++; $display("FAIL accept_after_release got %b%b required 11", a_accept, b_accept);
    end
    inv = 1'b1; tag = 11'h003;
    @(posedge clk); #1;
    idle_in();
    checks++;
    if (a_ack !== 1'b1) begin errors++; $display("FAIL pre_reset_ack got %b required 1", a_ack); end
    #2 rst_n = 1'b0;
    #1 checks++;
    if ({a_accept, obs_a(), b_accept, obs_b()} !== '0) begin
      errors++; $display("FAIL async_reset_outputs got %h/%h required 0", obs_a(), obs_b());
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (a_accept !== 1'b1) begin errors++; $display("FAIL accept_rerelease got %b required 1", a_accept); end
  endtask

  task automatic test_store_load();
    resp_t e, ra, rb;
    do_req(1'b0, 4'hF, 32'h10, 32'hDEADBEEF, 11'h005, 1'b0, 1'b0, 1'b0, e, ra, rb);
    checks++;
    if (ra !== e || ra.tag !== 11'h005 || ra.err !== 1'b0) begin
      errors++; $display("FAIL store_ack got %h required %h", ra, e);
    end
    checks++;
    if (rb !== e) begin errors++; $display("FAIL store_ack_lat3 got %h required %h", rb, e); end
    do_req(1'b1, 4'h0, 32'h10, 32'h0, 11'h006, 1'b0, 1'b0, 1'b0, e, ra, rb);
    checks++;
    if (ra.data !== 32'hDEADBEEF || ra !== e) begin
      errors++; $display("FAIL first_load got %h required %h", ra.data, 32'hDEADBEEF);
    end
  endtask

  task automatic test_byte_strobes();
    resp_t e, ra, rb;
    do_req(1'b0, 4'b0001, 32'h10, 32'h000000AA, 11'h010, 1'b0, 1'b0, 1'b0, e, ra, rb);
    do_req(1'b1, 4'h0, 32'h10, 32'h0, 11'h011, 1'b0, 1'b0, 1'b0, e, ra, rb);
    checks++;
    if (ra.data !== 32'hDEADBEAA) begin errors++; $display("FAIL strobe_lane0 got %h required deadbeaa", ra.data); end
    do_req(1'b0, 4'b1000, 32'h10, 32'hCC000000, 11'h012, 1'b0, 1'b0, 1'b0, e, ra, rb);
    do_req(1'b1, 4'h0, 32'h10, 32'h0, 11'h013, 1'b0, 1'b0, 1'b0, e, ra, rb);
    checks++;
    if (ra.data !== 32'hCCADBEAA) begin errors++; $display("FAIL strobe_lane3 got %h required ccadbeaa", ra.data); end
    checks++;
    if (rb !== e) begin errors++; $display("FAIL strobe_lat3 got %h required %h", rb, e); end
  endtask

  task automatic test_random();
    resp_t e, ra, rb;
    logic [31:0] ad;
    logic [3:0] w;
    int kind;
    for (int i = 0; i < 16; i++)
      do_req(1'b0, 4'hF, 32'(i * 4), $urandom, 11'(i), 1'b0, 1'b0, 1'b0, e, ra, rb);
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      ad = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h0000_1000)
                                       : {26'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
      w = 4'($urandom_range(1, 15));
      if (kind < 4)      do_req(1'b1, 4'h0, ad, $urandom, 11'($urandom), 1'b0, 1'b0, 1'b0, e, ra, rb);
      else if (kind < 8) do_req(1'b0, w, ad, $urandom, 11'($urandom), 1'b0, 1'b0, 1'b0, e, ra, rb);
      else if (kind == 8) do_req(1'b0, 4'h0, ad, $urandom, 11'($urandom), 1'($urandom), 1'b1, 1'b0, e, ra, rb);
      else               do_req(1'b1, w, ad, $urandom, 11'($urandom), 1'b0, 1'b0, 1'($urandom), e, ra, rb);
      checks++;
      if (ra !== e) begin errors++; $display("FAIL random_lat1 op%0d got %h required %h", n, ra, e); end
      checks++;
      if (rb !== e) begin errors++; $display("FAIL random_lat3 op%0d got %h required %h", n, rb, e); end
    end
  endtask

  // Store then four loads on consecutive cycles (first load hits the just-stored word).
  task automatic test_back_to_back();
    resp_t exp_q [5];
    resp_t ea, eb;
    logic [31:0] sw;
    sw = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
    issue(1'b0, 4'hF, sw, $urandom, 11'h7F0, 1'b0, 1'b0, 1'b0, exp_q[0]);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k < 4) issue(1'b1, 4'h0, (k == 0) ? sw : {26'h0, 4'($urandom_range(0, 15)), 2'b00},
                       32'h0, 11'(k + 1), 1'b0, 1'b0, 1'b0, exp_q[k+1]);
      else idle_in();
      ea = (k < 5) ? exp_q[k] : '0;
      eb = (k >= 2 && k < 7) ? exp_q[k-2] : '0;
      checks++;
      if (obs_a() !== ea) begin errors++; $display("FAIL b2b_lat1 k%0d got %h required %h", k, obs_a(), ea); end
      checks++;
      if (obs_b() !== eb) begin errors++; $display("FAIL b2b_lat3 k%0d got %h required %h", k, obs_b(), eb); end
    end
  endtask

  task automatic test_out_of_range();
    resp_t e, ra, rb;
    do_req(1'b1, 4'h0, 32'(4 * DEPTH), 32'h0, 11'h100, 1'b0, 1'b0, 1'b0, e, ra, rb);
    checks++;
    if (ra !== e || {ra.err, ra.lf, ra.sf} !== 3'b110 || ra.data !== 32'h0) begin
      errors++; $display("FAIL oor_load got %h required %h", ra, e);
    end
    do_req(1'b0, 4'hF, 32'(4 * DEPTH), 32'h5A5A5A5A, 11'h101, 1'b0, 1'b0, 1'b0, e, ra, rb);
    checks++;
    if (ra !== e || {ra.err, ra.lf, ra.sf} !== 3'b101) begin
      errors++; $display("FAIL oor_store got %h required %h", ra, e);
    end
    do_req(1'b1, 4'h0, 32'h0, 32'h0, 11'h102, 1'b0, 1'b0, 1'b0, e, ra, rb);
    checks++;
    if (ra !== e) begin errors++; $display("FAIL oor_word0 got %h required %h", ra, e); end
  endtask

  task automatic test_flush();
    resp_t ef, el;
    issue(1'b0, 4'h0, 32'h0, 32'h0, 11'h040, 1'b0, 1'b0, 1'b1, ef);
    @(posedge clk); #1;
    issue(1'b1, 4'h0, 32'h4, 32'h0, 11'h041, 1'b0, 1'b0, 1'b0, el);
    checks++;
    if (obs_a() !== ef || a_accept !== 1'b0) begin
      errors++; $display("FAIL flush_ack got %h accept %b required %h accept 0", obs_a(), a_accept, ef);
    end
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      checks++;
      if (a_accept !== (k == 8)) begin
        errors++; $display("FAIL flush_window k%0d got accept %b required %b", k, a_accept, k == 8);
      end
      checks++;
      if (k == 2 && obs_b() !== ef) begin
        errors++; $display("FAIL flush_ack_lat3 got %h required %h", obs_b(), ef);
      end else if (k != 2 && a_ack !== 1'b0) begin
        errors++; $display("FAIL flush_held_early k%0d got ack %b required 0", k, a_ack);
      end
    end
    @(posedge clk); #1;
    idle_in();
    checks++;
    if (obs_a() !== el) begin errors++; $display("FAIL flush_held_load got %h required %h", obs_a(), el); end
    repeat (2) @(posedge clk);
    #1 checks++;
    if (obs_b() !== el) begin errors++; $display("FAIL flush_held_lat3 got %h required %h", obs_b(), el); end
  endtask

  task automatic test_illegal();
    resp_t e, ra, rb;
    do_req(1'b1, 4'hF, 32'h10, 32'h12345678, 11'h7FF, 1'b0, 1'b0, 1'b0, e, ra, rb);
    checks++;
    if (ra !== e || {ra.err, ra.lf, ra.sf} !== 3'b100) begin
      errors++; $display("FAIL illegal_ack got %h required %h", ra, e);
    end
    do_req(1'b1, 4'h0, 32'h10, 32'h0, 11'h7FE, 1'b0, 1'b0, 1'b0, e, ra, rb);
    checks++;
    if (ra !== e) begin errors++; $display("FAIL illegal_unchanged got %h required %h", ra, e); end
    do_req(1'b1, 4'h0, 32'h10, 32'h0, 11'h7FD, 1'b0, 1'b0, 1'b1, e, ra, rb);
    checks++;
    if (ra !== e || a_accept !== 1'b1) begin
      errors++; $display("FAIL illegal_flush got %h accept %b required %h accept 1", ra, a_accept, e);
    end
  endtask

  task automatic test_reset_midflight();
    rd = 1'b1; addr = 32'h8; tag = 11'h333;
    @(posedge clk); #1;
    idle_in();
    #1 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      checks++;
      if (b_ack !== 1'b0) begin errors++; $display("FAIL dropped_ack k%0d got %b required 0", k, b_ack); end
    end
  endtask

  initial begin
    idle_in();
    test_reset();
    test_store_load();
    test_byte_strobes();
    test_random();
    test_back_to_back();
    test_out_of_range();
    test_flush();
    test_illegal();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
